// File: rtl/inst_loader.sv
// Boot-stream loader: length-prefixed words are written into instruction memory while the core is held.
// Optional trailing XOR checksum byte is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_i,
    output logic              byte_rdy_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         sr_q, sr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                rdy_q, rdy_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic        xfer;
    logic [15:0] n_new;
    logic        last_word;

    assign xfer      = byte_vld_i & rdy_q;
    assign n_new     = {byte_i, len_q[7:0]};
    assign last_word = ({{(32-ADDR_W){1'b0}}, idx_q} + 32'd1) == {16'd0, len_q};

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        len_d   = len_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
`ifdef INST_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            S_LEN: begin
                if (xfer) begin
                    if (bcnt_q == 2'd0) begin
                        len_d[7:0] = byte_i;
                        bcnt_d     = 2'd1;
                    end else begin
                        len_d  = n_new;
                        bcnt_d = 2'd0;
                        if (n_new == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end else if ({16'd0, n_new} > 32'(MEM_DEPTH)) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // first byte shifts down to bits 7:0 after four bytes
                    sr_d   = {byte_i, sr_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ byte_i;
`endif
                    if (bcnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + ADDR_W'(1);
                if (last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) state_d = (byte_i == chk_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    idx_d   = '0;
                    bcnt_d  = 2'd0;
                    len_d   = 16'd0;
`ifdef INST_LOADER_CHECKSUM_EN
                    chk_d   = 8'd0;
`endif
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    // outputs are registered from the next state so they line up with it
    always_comb begin
        rdy_d = (state_d == S_LEN) || (state_d == S_DATA);
`ifdef INST_LOADER_CHECKSUM_EN
        rdy_d = rdy_d || (state_d == S_CHK);
`endif
        we_d    = (state_d == S_WRITE);
        waddr_d = we_d ? idx_q : waddr_q;
        wdata_d = we_d ? sr_d : wdata_q;
        hold_d  = (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LEN;
            bcnt_q  <= 2'd0;
            len_q   <= 16'd0;
            sr_q    <= 32'd0;
            idx_q   <= '0;
            rdy_q   <= 1'b1;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            len_q   <= len_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign byte_rdy_o  = rdy_q;
    assign mem_we_o    = we_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_hold_o  = hold_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: streams are built from word lists and the
// expected write log is simply word i at address i, in order.
module tb_inst_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          byte_vld_i = 1'b0;
    logic [7:0]    byte_i = 8'd0;
    logic          byte_rdy_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_waddr_o;
    logic [31:0]   mem_wdata_o;
    logic          cpu_hold_o;
    logic          done_o;
    logic          err_o;

    inst_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .byte_vld_i(byte_vld_i), .byte_i(byte_i), .byte_rdy_o(byte_rdy_o),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          rdy_in_write = 0;

    always @(negedge clk) begin
        if (rst_n && mem_we_o) begin
            wr_addr.push_back(32'(mem_waddr_o));
            wr_data.push_back(mem_wdata_o);
            if (byte_rdy_o) rdy_in_write++;
        end
    end

    logic [31:0] words[$];
    logic [7:0]  strm[$];

    task automatic build_stream(input bit bad_chk);
        logic [7:0]  c;
        logic [15:0] n;
        c = 8'd0;
        n = 16'(words.size());
        strm.delete();
        strm.push_back(n[7:0]);
        strm.push_back(n[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) begin
                strm.push_back(words[i][8*b +: 8]);
                c = c ^ words[i][8*b +: 8];
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        strm.push_back(bad_chk ? (c ^ 8'h01) : c);
`else
        if (bad_chk) c = 8'd0;
`endif
    endtask

    task automatic send(input int stall_pct, input int start_at, input int nbytes);
        int tmo;
        for (int k = 0; k < nbytes && k < strm.size(); k++) begin
            while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                byte_vld_i = 1'b0;
                @(negedge clk);
            end
            byte_vld_i = 1'b1;
            byte_i     = strm[k];
            start_i    = (k == start_at);
            tmo = 0;
            while (!byte_rdy_o && tmo < 20) begin
                @(negedge clk);
                start_i = 1'b0;
                tmo++;
            end
            if (!byte_rdy_o) begin
                check("rdy_timeout", 32'(byte_rdy_o), 32'd1);
                break;
            end
            @(negedge clk);
            start_i = 1'b0;
        end
        byte_vld_i = 1'b0;
    endtask

    task automatic wait_end();
        int tmo;
        tmo = 0;
        while (!(done_o || err_o) && tmo < 10) begin
            @(negedge clk);
            tmo++;
        end
        if (!(done_o || err_o)) check("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic restart();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(words.size()));
        for (int i = 0; i < wr_addr.size() && i < words.size(); i++) begin
            check({tag, "_addr"}, wr_addr[i], 32'(i));
            check({tag, "_data"}, wr_data[i], words[i]);
        end
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic load_boot_words();
        words.delete();
        words.push_back(32'h0000_0013);
        words.push_back(32'h0010_0093);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hold",  32'(cpu_hold_o),  32'd1);
        check("rst_rdy",   32'(byte_rdy_o),  32'd1);
        check("rst_we",    32'(mem_we_o),    32'd0);
        check("rst_waddr", 32'(mem_waddr_o), 32'd0);
        check("rst_wdata", mem_wdata_o,      32'd0);
        check("rst_done",  32'(done_o),      32'd0);
        check("rst_err",   32'(err_o),       32'd0);

        load_boot_words();
        build_stream(1'b0);
        send(0, -1, strm.size());
        wait_end();
        check_writes("boot");
        check("boot_done", 32'(done_o),     32'd1);
        check("boot_hold", 32'(cpu_hold_o), 32'd0);
        check("boot_err",  32'(err_o),      32'd0);
        check("boot_rdy",  32'(byte_rdy_o), 32'd0);

        restart();
        send(0, -1, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, -1, strm.size());
        wait_end();
        check_writes("midrst");
        check("midrst_done", 32'(done_o), 32'd1);

        restart();
        send(40, 3, strm.size());
        wait_end();
        check_writes("reload");
        check("reload_done", 32'(done_o), 32'd1);

        restart();
        words.delete();
        build_stream(1'b0);
        send(0, -1, strm.size());
        wait_end();
        check_writes("n0");
        check("n0_done", 32'(done_o), 32'd1);

        restart();
        strm.delete();
        strm.push_back(8'h01);
        strm.push_back(8'h04);
        send(0, -1, 2);
        wait_end();
        check("big_err",  32'(err_o),          32'd1);
        check("big_hold", 32'(cpu_hold_o),     32'd1);
        check("big_rdy",  32'(byte_rdy_o),     32'd0);
        check("big_nwr",  32'(wr_addr.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("big_stay", 32'(err_o), 32'd1);
        restart();
        check("errrst_rdy", 32'(byte_rdy_o), 32'd1);
        check("errrst_err", 32'(err_o),      32'd0);

        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(8, 1);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            build_stream(1'b0);
            send(30, $urandom_range(strm.size() - 1, 0), strm.size());
            wait_end();
            check_writes("rand");
            check("rand_done", 32'(done_o), 32'd1);
            restart();
        end

        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        build_stream(1'b0);
        send(0, -1, strm.size());
        wait_end();
        check_writes("max");
        check("max_done", 32'(done_o), 32'd1);

`ifdef INST_LOADER_CHECKSUM_EN
        restart();
        load_boot_words();
        build_stream(1'b1);
        send(0, -1, strm.size());
        wait_end();
        check_writes("badchk");
        check("badchk_err",  32'(err_o),      32'd1);
        check("badchk_hold", 32'(cpu_hold_o), 32'd1);
`endif

        check("rdy_in_write", 32'(rdy_in_write), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
